pi_spi_link: RTL and testbench



---
 rtl/pi_spi_link_pkg.sv | 49 ++++
 rtl/pi_spi_link_sync.sv | 49 ++++
 rtl/pi_spi_link.sv | 153 +++++++++++++++
 tb/tb_pi_spi_link.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pi_spi_link_pkg.sv
// Shared PiBus types, region codes and FSM encoding for the MCU SPI link.
package pi_spi_link_pkg;

  typedef struct packed {
    logic ce_prg;
    logic ce_chr;
    logic ce_srm;
    logic ce_cfg;
    logic ce_fifo;
    logic ce_sst;
  } PiMap;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  dato;
    logic        we;
    logic        oe;
    logic        act;
    PiMap        map;
  } PiBus;

  localparam logic [7:0] PI_REG_PRG  = 8'h00;
  localparam logic [7:0] PI_REG_CHR  = 8'h01;
  localparam logic [7:0] PI_REG_SRM  = 8'h02;
  localparam logic [7:0] PI_REG_CFG  = 8'h08;
  localparam logic [7:0] PI_REG_FIFO = 8'h09;
  localparam logic [7:0] PI_REG_SST  = 8'h0A;
  localparam int         PI_CMD_RD   = 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_RDUMMY, ST_RDATA
  } pi_state_e;

  function automatic PiMap pi_map_decode(input logic [7:0] region);
    PiMap m;
    m = '0;
    case (region)
      PI_REG_PRG:  m.ce_prg  = 1'b1;
      PI_REG_CHR:  m.ce_chr  = 1'b1;
      PI_REG_SRM:  m.ce_srm  = 1'b1;
      PI_REG_CFG:  m.ce_cfg  = 1'b1;
      PI_REG_FIFO: m.ce_fifo = 1'b1;
      PI_REG_SST:  m.ce_sst  = 1'b1;
      default:     m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pi_spi_link_sync.sv
// Pin synchroniser; level and edge pulses share one extra flop so they stay aligned.
module spi_sync #(
  parameter int SYNC_LEN = 2,
  parameter bit EDGE     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_LEN-1:0] r_sync;
  logic                r_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_lvl  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_LEN-2:0], i_pin};
      r_lvl  <= r_sync[SYNC_LEN-1];
    end
  end

  assign o_lvl = r_lvl;

  generate
    if (EDGE) begin : g_edge
      logic r_rise, r_fall;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_rise <= r_sync[SYNC_LEN-1] & ~r_lvl;
          r_fall <= ~r_sync[SYNC_LEN-1] & r_lvl;
        end
      end
      assign o_rise = r_rise;
      assign o_fall = r_fall;
    end else begin : g_lvl
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pi_spi_link.sv
// SPI-slave (mode 0) to PiBus bridge: header decode, auto-increment, prefetched reads.
module pi_spi_link
  import pi_spi_link_pkg::*;
#(
  parameter int SYNC_LEN = 2,
  parameter int RD_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] dati,
  output PiBus       pi
);

  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_ss_lvl, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync #(.SYNC_LEN(SYNC_LEN), .EDGE(1'b1)) u_sck (
    .clk(clk), .rst(rst), .i_pin(spi_clk),
    .o_lvl(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_sync #(.SYNC_LEN(SYNC_LEN), .EDGE(1'b1)) u_ss (
    .clk(clk), .rst(rst), .i_pin(spi_ss),
    .o_lvl(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall));
  spi_sync #(.SYNC_LEN(SYNC_LEN), .EDGE(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .i_pin(spi_mosi),
    .o_lvl(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  assign w_unused = ^{w_sck_lvl, w_ss_rise, w_mosi_rise, w_mosi_fall};

  pi_state_e       r_state, w_state_nxt;
  logic [2:0]      r_bitcnt;
  logic [6:0]      r_shift;
  logic [1:0]      r_acnt;
  logic [23:0]     r_hdr;
  logic            r_rd;
  logic [31:0]     r_addr;
  logic [7:0]      r_dato, r_tx, r_txbuf;
  logic            r_we, r_oe, r_adv;
  logic [RD_LAT:1] r_oe_pipe;
  logic            w_byte_done, w_act, w_rd_bnd;
  logic [7:0]      w_byte;

  assign w_byte_done = w_sck_rise && (r_bitcnt == 3'd7) && (r_state != ST_IDLE);
  assign w_byte      = {r_shift, w_mosi};
  assign w_rd_bnd    = w_byte_done && (r_state == ST_RDUMMY || r_state == ST_RDATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A new frame needs a fresh ss falling edge, so a reset mid-frame drops the rest.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_IDLE) begin
      if (w_ss_fall) w_state_nxt = ST_CMD;
    end else if (w_ss_lvl) begin
      w_state_nxt = ST_IDLE;
    end else if (w_byte_done) begin
      case (r_state)
        ST_CMD:    w_state_nxt = ST_ADDR;
        ST_ADDR:   if (r_acnt == 2'd3) w_state_nxt = r_rd ? ST_RDUMMY : ST_WDATA;
        ST_RDUMMY: w_state_nxt = ST_RDATA;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_act       = (r_state != ST_IDLE);
    pi          = '0;
    pi.addr     = r_addr;
    pi.dato     = r_dato;
    pi.we       = r_we;
    pi.oe       = r_oe;
    pi.act      = w_act;
    pi.map      = w_act ? pi_map_decode(r_addr[31:24]) : '0;
    spi_miso    = w_act ? r_tx[7] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_acnt    <= '0;
      r_hdr     <= '0;
      r_rd      <= 1'b0;
      r_addr    <= '0;
      r_dato    <= '0;
      r_tx      <= 8'hFF;
      r_txbuf   <= 8'hFF;
      r_we      <= 1'b0;
      r_oe      <= 1'b0;
      r_adv     <= 1'b0;
      r_oe_pipe <= '0;
    end else begin
      r_we  <= 1'b0;
      r_oe  <= 1'b0;
      r_adv <= 1'b0;

      r_oe_pipe[1] <= r_oe;
      for (int i = 2; i <= RD_LAT; i++) r_oe_pipe[i] <= r_oe_pipe[i-1];
      if (r_oe_pipe[RD_LAT]) r_txbuf <= dati;

      if (r_state == ST_IDLE || w_ss_lvl) r_bitcnt <= '0;
      else if (w_sck_rise) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        r_shift  <= {r_shift[5:0], w_mosi};
      end

      if (r_state == ST_IDLE) r_acnt <= '0;

      if (w_we_or_adv()) r_addr <= r_addr + 32'd1;

      if (w_byte_done) begin
        case (r_state)
          ST_CMD:  r_rd <= w_byte[PI_CMD_RD];
          ST_ADDR: begin
            r_hdr  <= {r_hdr[15:0], w_byte};
            r_acnt <= r_acnt + 2'd1;
            if (r_acnt == 2'd3) begin
              r_addr <= {r_hdr, w_byte};
              r_oe   <= r_rd;
            end
          end
          ST_WDATA: begin
            r_dato <= w_byte;
            r_we   <= 1'b1;
          end
          ST_RDUMMY, ST_RDATA: r_adv <= 1'b1;
          default: ;
        endcase
      end
      // Prefetch for the next byte once the address has moved on.
      if (r_adv) r_oe <= 1'b1;

      // Skip the shift on the falling edge right after a byte boundary: bit7 is already out.
      if (r_state == ST_IDLE)                        r_tx <= 8'hFF;
      else if (w_rd_bnd)                             r_tx <= r_txbuf;
      else if (w_sck_fall && r_bitcnt != 3'd0)       r_tx <= {r_tx[6:0], 1'b1};
    end
  end

  function automatic logic w_we_or_adv();
    return r_we | r_adv;
  endfunction

endmodule

// File: tb/tb_pi_spi_link.sv
// Directed bench: drives SPI frames bit-by-bit, models a RD_LAT=2 target returning addr[7:0].
module tb_pi_spi_link;
  import pi_spi_link_pkg::*;

  localparam int HALF = 80;

  logic       clk = 1'b0, rst = 1'b1;
  logic       spi_clk = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] dati = 8'h00, t1 = 8'h00;
  PiBus       pi;

  always #5 clk = ~clk;

  pi_spi_link #(.SYNC_LEN(2), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_ss(spi_ss),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .dati(dati), .pi(pi));

  // Target: data valid two cycles after oe, equal to the low address byte.
  always @(posedge clk) begin
    if (pi.oe) t1 <= pi.addr[7:0];
    dati <= t1;
  end

  int          checks = 0, failures = 0;
  int          we_cnt = 0, oe_cnt = 0;
  logic [31:0] we_addr [8];
  logic [7:0]  we_data [8];
  logic [5:0]  we_map  [8];
  logic        we_act  [8];

  always @(negedge clk) begin
    if (pi.we && we_cnt < 8) begin
      we_addr[we_cnt] = pi.addr;
      we_data[we_cnt] = pi.dato;
      we_map[we_cnt]  = pi.map;
      we_act[we_cnt]  = pi.act;
    end
    if (pi.we) we_cnt++;
    if (pi.oe) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, input bit ss_on_last,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      #HALF;
      rx[i] = spi_miso;
      spi_clk = 1'b1;
      if (ss_on_last && i == 0) spi_ss = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] r;
    xfer(b, 8, 1'b0, r);
  endtask

  task automatic frame_start(input logic [7:0] cmd, input logic [31:0] a);
    we_cnt = 0;
    oe_cnt = 0;
    @(negedge clk);
    spi_ss = 1'b0;
    #(2*HALF);
    send(cmd);
    send(a[31:24]); send(a[23:16]); send(a[15:8]); send(a[7:0]);
  endtask

  task automatic frame_end();
    spi_ss = 1'b1;
    #(4*HALF);
  endtask

  logic [7:0] r;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_addr", pi.addr, 32'h0);
    chk("rst_dato", {24'h0, pi.dato}, 32'h0);
    chk("rst_we",   {31'h0, pi.we}, 32'h0);
    chk("rst_oe",   {31'h0, pi.oe}, 32'h0);
    chk("rst_act",  {31'h0, pi.act}, 32'h0);
    chk("rst_map",  {26'h0, pi.map}, 32'h0);
    chk("rst_miso", {31'h0, spi_miso}, 32'h1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Plain write burst into the cfg region
    frame_start(8'h00, 32'h0800_0010);
    send(8'hA5); send(8'h5A);
    frame_end();
    chk("wr_cnt",   we_cnt, 2);
    chk("wr0_addr", we_addr[0], 32'h0800_0010);
    chk("wr0_data", {24'h0, we_data[0]}, 32'hA5);
    chk("wr0_map",  {26'h0, we_map[0]}, 32'h04);
    chk("wr0_act",  {31'h0, we_act[0]}, 32'h1);
    chk("wr1_addr", we_addr[1], 32'h0800_0011);
    chk("wr1_data", {24'h0, we_data[1]}, 32'h5A);
    chk("wr_addr_after", pi.addr, 32'h0800_0012);
    chk("wr_act_after", {31'h0, pi.act}, 32'h0);
    chk("wr_oe_cnt", oe_cnt, 0);

    // Read burst: dummy then prefetched data
    frame_start(8'h01, 32'h0000_0100);
    xfer(8'hFF, 8, 1'b0, r); chk("rd_dummy", {24'h0, r}, 32'hFF);
    xfer(8'hFF, 8, 1'b0, r); chk("rd_d0", {24'h0, r}, 32'h00);
    xfer(8'hFF, 8, 1'b0, r); chk("rd_d1", {24'h0, r}, 32'h01);
    xfer(8'hFF, 8, 1'b0, r); chk("rd_d2", {24'h0, r}, 32'h02);
    frame_end();
    // one oe at header end plus one per byte after the header (dummy + 3 data)
    chk("rd_oe_cnt", oe_cnt, 5);
    chk("rd_addr_after", pi.addr, 32'h0000_0104);
    chk("rd_we_cnt", we_cnt, 0);

    // Abort after 5 bits of the second data byte
    frame_start(8'h00, 32'h0100_0020);
    send(8'h11);
    xfer(8'h22, 5, 1'b0, r);
    frame_end();
    chk("ab_cnt",  we_cnt, 1);
    chk("ab_addr", we_addr[0], 32'h0100_0020);
    chk("ab_data", {24'h0, we_data[0]}, 32'h11);
    chk("ab_map",  {26'h0, we_map[0]}, 32'h10);
    frame_start(8'h00, 32'h0200_0000);
    send(8'h33);
    frame_end();
    chk("nx_cnt",  we_cnt, 1);
    chk("nx_addr", we_addr[0], 32'h0200_0000);
    chk("nx_data", {24'h0, we_data[0]}, 32'h33);
    chk("nx_map",  {26'h0, we_map[0]}, 32'h08);

    // Address wrap
    frame_start(8'h00, 32'hFFFF_FFFF);
    send(8'h01); send(8'h02);
    frame_end();
    chk("wrap_cnt",   we_cnt, 2);
    chk("wrap0_addr", we_addr[0], 32'hFFFF_FFFF);
    chk("wrap0_map",  {26'h0, we_map[0]}, 32'h00);
    chk("wrap1_addr", we_addr[1], 32'h0000_0000);
    chk("wrap1_data", {24'h0, we_data[1]}, 32'h02);
    chk("wrap1_map",  {26'h0, we_map[1]}, 32'h20);

    // Reset pulse in the middle of a read
    frame_start(8'h01, 32'h0000_0200);
    xfer(8'hFF, 8, 1'b0, r);
    xfer(8'hFF, 3, 1'b0, r);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mrst_miso", {31'h0, spi_miso}, 32'h1);
    chk("mrst_act",  {31'h0, pi.act}, 32'h0);
    chk("mrst_addr", pi.addr, 32'h0);
    oe_cnt = 0;
    xfer(8'hFF, 5, 1'b0, r);
    xfer(8'h00, 8, 1'b0, r);
    chk("mrst_rx",    {24'h0, r}, 32'hFF);
    chk("mrst_oe",    oe_cnt, 0);
    chk("mrst_act2",  {31'h0, pi.act}, 32'h0);
    chk("mrst_we",    we_cnt, 0);
    frame_end();

    // Last data bit and ss rise land in the same cycle
    frame_start(8'h00, 32'h0900_0005);
    xfer(8'hC3, 8, 1'b1, r);
    #(4*HALF);
    chk("co_cnt",  we_cnt, 1);
    chk("co_addr", we_addr[0], 32'h0900_0005);
    chk("co_data", {24'h0, we_data[0]}, 32'hC3);
    chk("co_act_at_we", {31'h0, we_act[0]}, 32'h0);
    chk("co_act_after", {31'h0, pi.act}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
